consec_scan_sched: RTL and testbench

Round-robin scan controller for the consecutive-ones detector datapath. It drives the 4:1 channel select `SEL` over a software-enabled subset of the four `inputvals` lanes and samples the selected bit each cycle. For each channel it tracks the run length of consecutive ones and raises a sticky per-channel hit flag plus a global `consec4` flag when a run reaches `THRESH`. It sits between the input lanes and the shift-register/flag outputs. It replaces free-running select logic with a start/abort/done-sequenced scan.

---
 rtl/consec_scan_sched.sv | 190 +++++++++++++++++++
 tb/tb_consec_scan_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/consec_scan_sched.sv
// consec_scan_sched
// Round-robin scan controller for the consecutive-ones detector datapath.
// A session is launched with start: the enable mask is latched and the
// channel select walks the enabled lanes one per cycle for ROUNDS full rounds.
// Each sample updates that channel's run counter and sticky hit flag.
//
// Ports
//   CLK          rising-edge clock
//   RST          asynchronous reset, active high
//   inputvals    one data bit per channel
//   en_mask      channel enable mask, latched on an accepted start
//   start        begin a session (IDLE only)
//   abort        end the session early, without a done pulse (SCAN only)
//   clear        zero hit flags and run counters (IDLE only)
//   SEL          current channel select
//   samp_bit     combinational inputvals[SEL]
//   final_sr_out last four sampled bits, newest in bit 0
//   hit          sticky per-channel threshold flags
//   consec4      registered OR of hit
//   busy         high while scanning
//   done         one-cycle pulse at normal session end
module consec_scan_sched #(
    parameter int THRESH = 4,
    parameter int CNTW   = 3,
    parameter int ROUNDS = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] inputvals,
    input  logic [3:0] en_mask,
    input  logic       start,
    input  logic       abort,
    input  logic       clear,
    output logic [1:0] SEL,
    output logic       samp_bit,
    output logic [3:0] final_sr_out,
    output logic [3:0] hit,
    output logic       consec4,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_HIT = CNTW'(THRESH - 1);
    localparam logic [7:0]      ROUNDS_L = 8'(ROUNDS);

    state_t                   state_q, state_d;
    logic [1:0]               sel_q, sel_d;
    logic [3:0]               mask_q, mask_d;
    logic [3:0]               sr_q, sr_d;
    logic [3:0]               hit_q, hit_d;
    logic                     consec4_q, consec4_d;
    logic [3:0][CNTW-1:0]     cnt_q, cnt_d;
    logic [7:0]               round_q, round_d;

    // Lowest set bit of a mask; returns 0 for an empty mask.
    function automatic logic [1:0] lowest_chan(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Highest set bit of a mask; the round ends when this channel is sampled.
    function automatic logic [1:0] highest_chan(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Searching upward modulo 4 gives "next above, else wrap to lowest";
    // a single-channel mask finds nothing and the select holds.
    function automatic logic [1:0] next_chan(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] r;
        logic [1:0] c;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i < 4; i++) begin
            c = cur + 2'(i);
            if (!found && m[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign samp_bit = inputvals[sel_q];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        mask_d    = mask_q;
        sr_d      = sr_q;
        hit_d     = hit_q;
        cnt_d     = cnt_q;
        round_d   = round_q;
        consec4_d = |hit_q;

        case (state_q)
            IDLE: begin
                // clear is applied first so a simultaneous start begins from zero.
                if (clear) begin
                    cnt_d = '0;
                    hit_d = '0;
                end
                if (start) begin
                    if (en_mask != 4'd0) begin
                        mask_d  = en_mask;
                        sel_d   = lowest_chan(en_mask);
                        round_d = 8'd0;
                        state_d = SCAN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            SCAN: begin
                sr_d = {sr_q[2:0], samp_bit};
                if (samp_bit) begin
                    if (cnt_q[sel_q] != CNT_MAX) cnt_d[sel_q] = cnt_q[sel_q] + 1'b1;
                    if (cnt_q[sel_q] == CNT_HIT) hit_d[sel_q] = 1'b1;
                end else begin
                    cnt_d[sel_q] = '0;
                end

                sel_d = next_chan(mask_q, sel_q);

                if (sel_q == highest_chan(mask_q)) begin
                    round_d = round_q + 8'd1;
                    if (round_d == ROUNDS_L) state_d = DONE;
                end

                // Abort wins over a session that would otherwise finish now.
                if (abort) state_d = IDLE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            mask_q    <= 4'd0;
            sr_q      <= 4'd0;
            hit_q     <= 4'd0;
            consec4_q <= 1'b0;
            cnt_q     <= '0;
            round_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            mask_q    <= mask_d;
            sr_q      <= sr_d;
            hit_q     <= hit_d;
            consec4_q <= consec4_d;
            cnt_q     <= cnt_d;
            round_q   <= round_d;
        end
    end

    assign SEL          = sel_q;
    assign final_sr_out = sr_q;
    assign hit          = hit_q;
    assign consec4      = consec4_q;
    assign busy         = (state_q == SCAN);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_consec_scan_sched.sv
// Directed testbench for consec_scan_sched with hand-computed expectations.
module tb_consec_scan_sched;

    logic       CLK;
    logic       RST;
    logic [3:0] inputvals;
    logic [3:0] en_mask;
    logic       start;
    logic       abort;
    logic       clear;
    logic [1:0] SEL;
    logic       samp_bit;
    logic [3:0] final_sr_out;
    logic [3:0] hit;
    logic       consec4;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    consec_scan_sched #(.THRESH(4), .CNTW(3), .ROUNDS(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .inputvals    (inputvals),
        .en_mask      (en_mask),
        .start        (start),
        .abort        (abort),
        .clear        (clear),
        .SEL          (SEL),
        .samp_bit     (samp_bit),
        .final_sr_out (final_sr_out),
        .hit          (hit),
        .consec4      (consec4),
        .busy         (busy),
        .done         (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive all control inputs at once.
    task automatic applyStimulus(input logic st, input logic ab, input logic cl,
                                 input logic [3:0] m, input logic [3:0] v);
        start     = st;
        abort     = ab;
        clear     = cl;
        en_mask   = m;
        inputvals = v;
    endtask

    // Advance one active edge; outputs are examined 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] exp_hit;
        logic [7:0] bits;
        int         exp_cnt;

        checks = 0;
        errors = 0;
        RST    = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        tick();
        tick();
        RST = 1'b0;
        tick();

        // ---- reset asserted during SCAN ----
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
        tick();
        tick();
        checkOutput("pre_rst_busy", busy, 1);
        #2 RST = 1'b1;
        #1;
        checkOutput("rst_sel", SEL, 0);
        checkOutput("rst_sr", final_sr_out, 0);
        checkOutput("rst_hit", hit, 0);
        checkOutput("rst_consec4", consec4, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        tick();
        RST = 1'b0;
        tick();

        // ---- all enabled, all ones ----
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
        checkOutput("all_busy_start", busy, 1);
        for (int s = 1; s <= 32; s++) begin
            checkOutput("all_sel", SEL, (s - 1) % 4);
            tick();
            exp_hit = 4'b0000;
            for (int ch = 0; ch < 4; ch++) begin
                if (s >= 13 + ch) exp_hit[ch] = 1'b1;
            end
            checkOutput("all_hit", hit, exp_hit);
            checkOutput("all_consec4", consec4, (s >= 14) ? 1 : 0);
            checkOutput("all_done", done, (s == 32) ? 1 : 0);
        end
        checkOutput("all_busy_end", busy, 0);
        tick();
        checkOutput("all_done_after", done, 0);
        checkOutput("all_busy_after", busy, 0);

        // ---- sparse mask ----
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
        tick();
        checkOutput("clr_hit", hit, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1010, 4'b1111);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1010, 4'b1111);
        for (int s = 1; s <= 16; s++) begin
            checkOutput("sparse_sel", SEL, (s % 2 == 1) ? 1 : 3);
            tick();
            checkOutput("sparse_done", done, (s == 16) ? 1 : 0);
        end
        checkOutput("sparse_hit", hit, 4'b1010);
        tick();

        // ---- broken run on ch0 ----
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000);
        tick();
        bits = 8'b1111_0111;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, {3'b000, bits[i]});
            checkOutput("broken_sel", SEL, 0);
            tick();
            checkOutput("broken_hit0", hit[0], (i == 7) ? 1 : 0);
            checkOutput("broken_done", done, (i == 7) ? 1 : 0);
        end
        checkOutput("broken_sr", final_sr_out, 4'b1111);
        tick();

        // ---- empty mask ----
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111);
        tick();
        checkOutput("empty_done", done, 1);
        checkOutput("empty_busy", busy, 0);
        checkOutput("empty_hit", hit, 4'b0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111);
        tick();
        checkOutput("empty_done_after", done, 0);
        checkOutput("empty_busy_after", busy, 0);

        // ---- abort with start held during SCAN ----
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111);
        tick();
        for (int s = 1; s <= 5; s++) begin
            checkOutput("abort_sel", SEL, (s - 1) % 4);
            if (s == 5) applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111);
            tick();
            if (s < 5) checkOutput("abort_busy", busy, 1);
        end
        checkOutput("abort_idle_busy", busy, 0);
        checkOutput("abort_no_done", done, 0);
        checkOutput("abort_hit", hit, 4'b0001);
        checkOutput("abort_sr", final_sr_out, 4'b1111);
        checkOutput("abort_consec4", consec4, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
        tick();
        checkOutput("abort_no_done2", done, 0);
        checkOutput("abort_busy2", busy, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111, 4'b1111);
        tick();
        checkOutput("abort_clr_hit", hit, 0);
        checkOutput("abort_clr_c4_hold", consec4, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        tick();
        checkOutput("abort_clr_c4_drop", consec4, 0);

        // ---- saturation on ch0 ----
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001);
        for (int s = 1; s <= 8; s++) begin
            tick();
            exp_cnt = (s > 7) ? 7 : s;
            checkOutput("sat_cnt", dut.cnt_q[0], exp_cnt);
            checkOutput("sat_hit0", hit[0], (s >= 4) ? 1 : 0);
        end
        checkOutput("sat_done", done, 1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001);
        for (int s = 9; s <= 10; s++) begin
            tick();
            checkOutput("sat_cnt_hold", dut.cnt_q[0], 7);
            checkOutput("sat_hit_hold", hit[0], 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000);
        tick();
        checkOutput("sat_cnt_zero", dut.cnt_q[0], 0);
        checkOutput("sat_hit_kept", hit[0], 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000);
        tick();
        checkOutput("sat_abort_busy", busy, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
